uart_mem_loader: RTL and testbench

- Memory-bus initiator that fills data memory from a host over UART, using the same addr/WriteData/MemRead/MemWrite bus that the data memory answers.
- Receives 8N1 serial bytes and packs each group of 4 into a little-endian 32-bit word.
- Issues one single-cycle write per word at consecutive word addresses from BASE_ADDR.
- Sits beside the CPU; an external mux gives it the bus while busy=1.

---
 rtl/uart_mem_loader.sv | 183 ++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives 8N1 bytes over UART, packs groups of four into
// little-endian words and writes them to data memory at consecutive word
// addresses starting at BASE_ADDR. The bus belongs to this block while busy=1.
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WORD_COUNT   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  output logic [31:0] addr,
  output logic [31:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int WW   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_RECV, L_WRITE, L_DONE} ld_state_t;

  rx_state_t       rx_state, rx_next;
  ld_state_t       ld_state, ld_next;

  logic            rx_meta, rx_sync;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            cnt_clr, sample, byte_valid, stop_bad;

  logic [WW-1:0]   word_idx;
  logic [1:0]      byte_idx;
  logic [3:0][7:0] word_buf;
  logic [3:0][7:0] word_next;
  logic            last_word;

  wire half_pt = (clk_cnt == CW'(HALF));
  wire bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  assign MemRead   = 1'b0;
  assign last_word = (word_idx == WW'(WORD_COUNT - 1));

  // Two-flop synchronizer; idle-high so reset does not look like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // RX FSM next state; byte_valid fires in the cycle the good stop bit is sampled
  always_comb begin
    rx_next    = rx_state;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state)
      R_IDLE:  if (!rx_sync) begin
                 rx_next = R_START;
                 cnt_clr = 1'b1;
               end
      R_START: if (half_pt) begin
                 cnt_clr = 1'b1;
                 rx_next = rx_sync ? R_IDLE : R_DATA;
               end
      R_DATA:  if (bit_end) begin
                 cnt_clr = 1'b1;
                 sample  = 1'b1;
                 if (bit_cnt == 3'd7) rx_next = R_STOP;
               end
      R_STOP:  if (bit_end) begin
                 cnt_clr = 1'b1;
                 rx_next = R_IDLE;
                 if (rx_sync) byte_valid = 1'b1;
                 else         stop_bad   = 1'b1;
               end
      default: rx_next = R_IDLE;
    endcase
  end

  // RX datapath: cycle counter, bit counter, LSB-first shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (cnt_clr || rx_state == R_IDLE) clk_cnt <= '0;
      else                               clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == R_START) bit_cnt <= '0;
      else if (sample)         bit_cnt <= bit_cnt + 1'b1;
      if (sample) shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

  // Word being assembled with the incoming byte merged into its lane
  always_comb begin
    word_next           = word_buf;
    word_next[byte_idx] = shift_reg;
  end

  // Loader FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_state <= L_IDLE;
    else        ld_state <= ld_next;
  end

  // Loader FSM next state and bus strobes; MemWrite is tied to the state so
  // an async reset drops it immediately
  always_comb begin
    ld_next  = ld_state;
    busy     = 1'b0;
    MemWrite = 1'b0;
    case (ld_state)
      L_IDLE:  if (start) ld_next = L_RECV;
      L_RECV:  begin
                 busy = 1'b1;
                 if (byte_valid && byte_idx == 2'd3) ld_next = L_WRITE;
               end
      L_WRITE: begin
                 busy     = 1'b1;
                 MemWrite = 1'b1;
                 ld_next  = last_word ? L_DONE : L_RECV;
               end
      L_DONE:  ld_next = L_IDLE;
      default: ld_next = L_IDLE;
    endcase
  end

  // Loader datapath: indices, word buffer, registered bus outputs, sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      addr      <= '0;
      WriteData <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (ld_state)
        L_IDLE:  if (start) begin
                   word_idx  <= '0;
                   byte_idx  <= '0;
                   done      <= 1'b0;
                   frame_err <= 1'b0;
                 end
        L_RECV:  if (byte_valid) begin
                   word_buf <= word_next;
                   byte_idx <= byte_idx + 1'b1;
                   if (byte_idx == 2'd3) begin
                     WriteData <= word_next;
                     addr      <= BASE_ADDR + (32'(word_idx) << 2);
                   end
                 end
        L_WRITE: if (last_word) done <= 1'b1;
                 else           word_idx <= word_idx + 1'b1;
        default: ;
      endcase
      // a bad stop bit is recorded in any state; start clears it only when
      // no error arrives in the same cycle
      if (stop_bad) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: dut_a (BASE 0, 512 words) covers the
// single-word, framing, glitch and abort cases; dut_b (BASE 0x100, 2 words)
// covers session end. Both share rx and reset.
module tb_uart_mem_loader;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic        mr_a, mw_a, busy_a, done_a, fe_a;
  logic        mr_b, mw_b, busy_b, done_b, fe_b;

  int errors = 0;
  int checks = 0;

  // write monitors (cumulative; tests take deltas)
  int          wr_a = 0, wr_b = 0, dbl_a = 0;
  logic        mw_a_q = 1'b0;
  logic [31:0] b_addr [4];
  logic [31:0] b_data [4];

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .WORD_COUNT(512)) dut_a (
    .clk(clk), .reset(reset), .rx(rx), .start(start_a),
    .addr(addr_a), .WriteData(wd_a), .MemRead(mr_a), .MemWrite(mw_a),
    .busy(busy_a), .done(done_a), .frame_err(fe_a));

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h100), .WORD_COUNT(2)) dut_b (
    .clk(clk), .reset(reset), .rx(rx), .start(start_b),
    .addr(addr_b), .WriteData(wd_b), .MemRead(mr_b), .MemWrite(mw_b),
    .busy(busy_b), .done(done_b), .frame_err(fe_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mw_a) wr_a++;
    if (mw_a && mw_a_q) dbl_a++;
    mw_a_q = mw_a;
    if (mw_b) begin
      if (wr_b < 4) begin
        b_addr[wr_b] = addr_b;
        b_data[wr_b] = wd_b;
      end
      wr_b++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx      = i[0];
      start_a = i[1];
      start_b = i[1];
    end
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    checks++; if (addr_a !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", addr_a, 32'h0); end
    checks++; if (wd_a !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want %h", wd_a, 32'h0); end
    checks++; if (mw_a !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b want 0", mw_a); end
    checks++; if (mr_a !== 1'b0) begin errors++; $display("FAIL reset_memread: got %b want 0", mr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", fe_a); end
    checks++; if ({busy_b, mw_b, done_b} !== 3'b000) begin errors++; $display("FAIL reset_b_flags: got %b want 000", {busy_b, mw_b, done_b}); end
    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_word();
    int w0, d0;
    logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    pulse_reset();
    w0 = wr_a; d0 = dbl_a;
    pulse_start_a();
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy byte%0d: got %b want 1", i, busy_a); end
      send_byte(bytes[i], 1'b1);
    end
    checks++; if (wr_a - w0 !== 1) begin errors++; $display("FAIL single_write_count: got %0d want 1", wr_a - w0); end
    checks++; if (dbl_a - d0 !== 0) begin errors++; $display("FAIL single_pulse_width: got %0d extra cycles want 0", dbl_a - d0); end
    checks++; if (addr_a !== 32'h0000_0000) begin errors++; $display("FAIL single_addr: got %h want %h", addr_a, 32'h0); end
    checks++; if (wd_a !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata: got %h want %h", wd_a, 32'h1234_5678); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_after: got %b want 1", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_done: got %b want 0", done_a); end
  endtask

  task automatic test_session_end();
    int w0;
    pulse_reset();
    w0 = wr_b;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    checks++; if (wr_b - w0 !== 2) begin errors++; $display("FAIL end_write_count: got %0d want 2", wr_b - w0); end
    checks++; if (b_addr[w0] !== 32'h100) begin errors++; $display("FAIL end_addr0: got %h want %h", b_addr[w0], 32'h100); end
    checks++; if (b_data[w0] !== 32'h0403_0201) begin errors++; $display("FAIL end_data0: got %h want %h", b_data[w0], 32'h0403_0201); end
    checks++; if (b_addr[w0+1] !== 32'h104) begin errors++; $display("FAIL end_addr1: got %h want %h", b_addr[w0+1], 32'h104); end
    checks++; if (b_data[w0+1] !== 32'h0807_0605) begin errors++; $display("FAIL end_data1: got %h want %h", b_data[w0+1], 32'h0807_0605); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL end_done: got %b want 1", done_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL end_busy: got %b want 0", busy_b); end
    send_byte(8'h09, 1'b1);
    checks++; if (wr_b - w0 !== 2) begin errors++; $display("FAIL end_ninth_byte: got %0d writes want 2", wr_b - w0); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL end_done_sticky: got %b want 1", done_b); end
  endtask

  task automatic test_frame_err();
    int w0;
    pulse_reset();
    w0 = wr_a;
    pulse_start_a();
    send_byte(8'hAA, 1'b0);
    checks++; if (fe_a !== 1'b1) begin errors++; $display("FAIL fe_set: got %b want 1", fe_a); end
    checks++; if (wr_a - w0 !== 0) begin errors++; $display("FAIL fe_no_write: got %0d want 0", wr_a - w0); end
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    checks++; if (fe_a !== 1'b1) begin errors++; $display("FAIL fe_sticky: got %b want 1", fe_a); end
    checks++; if (wr_a - w0 !== 1) begin errors++; $display("FAIL fe_write_count: got %0d want 1", wr_a - w0); end
    checks++; if (wd_a !== 32'h4433_2211) begin errors++; $display("FAIL fe_wdata: got %h want %h", wd_a, 32'h4433_2211); end
    checks++; if (addr_a !== 32'h0) begin errors++; $display("FAIL fe_addr: got %h want %h", addr_a, 32'h0); end
  endtask

  task automatic test_glitch();
    int w0;
    pulse_reset();
    w0 = wr_a;
    pulse_start_a();
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    checks++; if (wr_a - w0 !== 1) begin errors++; $display("FAIL glitch_write_count: got %0d want 1", wr_a - w0); end
    checks++; if (wd_a !== 32'hEFBE_ADDE) begin errors++; $display("FAIL glitch_wdata: got %h want %h", wd_a, 32'hEFBE_ADDE); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", fe_a); end
  endtask

  task automatic test_abort_and_ignore();
    int w0;
    pulse_reset();
    pulse_start_a();
    send_byte(8'h99, 1'b1);
    send_byte(8'h98, 1'b1);
    // third byte: start bit and three data bits, then reset
    @(negedge clk) rx = 1'b0;
    repeat (4 * CPB - 1) @(negedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checks++; if (mw_a !== 1'b0) begin errors++; $display("FAIL abort_memwrite: got %b want 0", mw_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    w0 = wr_a;
    pulse_start_a();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    checks++; if (wr_a - w0 !== 1) begin errors++; $display("FAIL abort_write_count: got %0d want 1", wr_a - w0); end
    checks++; if (addr_a !== 32'h0) begin errors++; $display("FAIL abort_addr: got %h want %h", addr_a, 32'h0); end
    checks++; if (wd_a !== 32'h0403_0201) begin errors++; $display("FAIL abort_wdata: got %h want %h", wd_a, 32'h0403_0201); end
    // start while receiving must not restart the word index
    pulse_start_a();
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b1);
    checks++; if (wr_a - w0 !== 2) begin errors++; $display("FAIL ignore_write_count: got %0d want 2", wr_a - w0); end
    checks++; if (addr_a !== 32'h4) begin errors++; $display("FAIL ignore_addr: got %h want %h", addr_a, 32'h4); end
    checks++; if (wd_a !== 32'h0807_0605) begin errors++; $display("FAIL ignore_wdata: got %h want %h", wd_a, 32'h0807_0605); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_session_end();
    test_frame_err();
    test_glitch();
    test_abort_and_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
